rt_response_sequencer: RTL and testbench

- Remote-terminal response controller for the 1553 transmit path.
- Accepts a decoded, validated command word and waits the response gap. Then drives the word encoder: one status word, followed by 0..32 data words fetched from a transmit buffer.
- Sits between the command decoder / subaddress buffer and the encoder. Owns the tx_csw/tx_dw strobes and the word presented to the encoder.

---
 rtl/rt_response_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_rt_response_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rt_response_sequencer.sv
// 1553 remote-terminal response sequencer: waits the response gap, then drives
// the word encoder with one status word followed by 0..32 buffered data words.
module rt_response_sequencer #(
  parameter int unsigned RESP_GAP  = 10,
  parameter int unsigned START_TMO = 4
) (
  input  logic        enc_clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [0:15] cmd_word,
  input  logic [0:4]  own_address,
  input  logic [0:10] status_flags,
  input  logic        abort,
  input  logic        enc_busy,
  input  logic [0:15] buf_rd_data,
  output logic        buf_rd_en,
  output logic [4:0]  buf_rd_addr,
  output logic [0:4]  buf_sa,
  output logic        tx_csw,
  output logic        tx_dw,
  output logic [0:15] tx_word,
  output logic        seq_busy,
  output logic        resp_done,
  output logic        resp_err
);

  localparam int unsigned GAP_W = $clog2(RESP_GAP + 1);
  localparam int unsigned TMO_W = $clog2(START_TMO + 1);
  localparam int unsigned CNT_W = 6;

  typedef enum logic [2:0] {
    IDLE, GAP, SW_STROBE, SW_WAIT, FETCH, DW_STROBE, DW_WAIT, DONE
  } state_e;

  state_e             state_q, state_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               rise_q, rise_d;
  logic               ph_q, ph_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   nwords_q, nwords_d;
  logic               timeout_c;
  logic               abort_c;

  logic               buf_rd_en_d, tx_csw_d, tx_dw_d, seq_busy_d, resp_done_d, resp_err_d;
  logic [4:0]         buf_rd_addr_d;
  logic [0:4]         buf_sa_d;
  logic [0:15]        tx_word_d;

  logic [4:0] cmd_rt, cmd_sa, cmd_cnt;
  logic       cmd_tr;
  assign cmd_rt  = cmd_word[0:4];
  assign cmd_tr  = cmd_word[5];
  assign cmd_sa  = cmd_word[6:10];
  assign cmd_cnt = cmd_word[11:15];

  assign abort_c = abort && (state_q != IDLE);

  // State, counters and registered outputs
  always_ff @(posedge enc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gap_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      rise_q      <= 1'b0;
      ph_q        <= 1'b0;
      idx_q       <= '0;
      nwords_q    <= '0;
      buf_rd_en   <= 1'b0;
      buf_rd_addr <= '0;
      buf_sa      <= '0;
      tx_csw      <= 1'b0;
      tx_dw       <= 1'b0;
      tx_word     <= '0;
      seq_busy    <= 1'b0;
      resp_done   <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      rise_q      <= rise_d;
      ph_q        <= ph_d;
      idx_q       <= idx_d;
      nwords_q    <= nwords_d;
      buf_rd_en   <= buf_rd_en_d;
      buf_rd_addr <= buf_rd_addr_d;
      buf_sa      <= buf_sa_d;
      tx_csw      <= tx_csw_d;
      tx_dw       <= tx_dw_d;
      tx_word     <= tx_word_d;
      seq_busy    <= seq_busy_d;
      resp_done   <= resp_done_d;
      resp_err    <= resp_err_d;
    end
  end

  // Next state and counters
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    rise_d    = rise_q;
    ph_d      = ph_q;
    idx_d     = idx_q;
    nwords_d  = nwords_q;
    timeout_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && (cmd_rt == own_address) && (cmd_rt != 5'd31)) begin
          state_d   = GAP;
          gap_cnt_d = '0;
          idx_d     = '0;
          if (cmd_tr && (cmd_sa != 5'd0) && (cmd_sa != 5'd31))
            nwords_d = (cmd_cnt == 5'd0) ? CNT_W'(32) : CNT_W'(cmd_cnt);
          else
            nwords_d = '0;
        end
      end
      GAP: begin
        // Hold at the end of the gap while a previously aborted word drains
        if (gap_cnt_q == GAP_W'(RESP_GAP - 1)) begin
          if (!enc_busy) state_d = SW_STROBE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      SW_STROBE, DW_STROBE: begin
        state_d   = (state_q == SW_STROBE) ? SW_WAIT : DW_WAIT;
        tmo_cnt_d = TMO_W'(1);
        rise_d    = 1'b0;
      end
      SW_WAIT, DW_WAIT: begin
        if (!rise_q) begin
          if (enc_busy) begin
            rise_d = 1'b1;
          end else if (tmo_cnt_q >= TMO_W'(START_TMO - 1)) begin
            timeout_c = 1'b1;
            state_d   = IDLE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          end
        end else if (!enc_busy) begin
          ph_d = 1'b0;
          if (state_q == SW_WAIT) begin
            state_d = (nwords_q == '0) ? DONE : FETCH;
          end else begin
            idx_d   = idx_q + CNT_W'(1);
            state_d = (idx_d == nwords_q) ? DONE : FETCH;
          end
        end
      end
      FETCH: begin
        if (!ph_q) ph_d = 1'b1;
        else       state_d = DW_STROBE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_c) begin
      state_d   = IDLE;
      timeout_c = 1'b0;
    end
  end

  // Output next values, registered above
  always_comb begin
    seq_busy_d    = (state_d != IDLE) && (state_d != DONE);
    tx_csw_d      = (state_d == SW_STROBE);
    tx_dw_d       = (state_d == DW_STROBE);
    buf_rd_en_d   = (state_d == FETCH) && !ph_d;
    resp_done_d   = (state_d == DONE);
    resp_err_d    = timeout_c;
    buf_rd_addr_d = buf_rd_addr;
    buf_sa_d      = buf_sa;
    tx_word_d     = tx_word;
    if (state_q == IDLE && state_d == GAP) begin
      buf_sa_d      = cmd_sa;
      buf_rd_addr_d = '0;
    end
    if (state_q == GAP && state_d == SW_STROBE) tx_word_d = {own_address, status_flags};
    if (buf_rd_en_d) buf_rd_addr_d = idx_d[4:0];
    if (state_q == FETCH && ph_q) tx_word_d = buf_rd_data;
    if (abort_c) begin
      seq_busy_d    = 1'b0;
      tx_csw_d      = 1'b0;
      tx_dw_d       = 1'b0;
      buf_rd_en_d   = 1'b0;
      resp_done_d   = 1'b0;
      resp_err_d    = 1'b0;
      buf_rd_addr_d = '0;
      buf_sa_d      = '0;
      tx_word_d     = '0;
    end
  end

endmodule

// File: tb/tb_rt_response_sequencer.sv
// Scoreboard bench for rt_response_sequencer with encoder and transmit-buffer models.
module tb_rt_response_sequencer;

  localparam int unsigned RESP_GAP  = 10;
  localparam int unsigned START_TMO = 4;

  logic        enc_clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [0:15] cmd_word;
  logic [0:4]  own_address;
  logic [0:10] status_flags;
  logic        abort;
  logic        enc_busy = 1'b0;
  logic [0:15] buf_rd_data = '0;
  logic        buf_rd_en;
  logic [4:0]  buf_rd_addr;
  logic [0:4]  buf_sa;
  logic        tx_csw, tx_dw;
  logic [0:15] tx_word;
  logic        seq_busy, resp_done, resp_err;

  always #5 enc_clk = ~enc_clk;

  rt_response_sequencer #(.RESP_GAP(RESP_GAP), .START_TMO(START_TMO)) dut (
    .enc_clk(enc_clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_word(cmd_word),
    .own_address(own_address), .status_flags(status_flags), .abort(abort),
    .enc_busy(enc_busy), .buf_rd_data(buf_rd_data), .buf_rd_en(buf_rd_en),
    .buf_rd_addr(buf_rd_addr), .buf_sa(buf_sa), .tx_csw(tx_csw), .tx_dw(tx_dw),
    .tx_word(tx_word), .seq_busy(seq_busy), .resp_done(resp_done), .resp_err(resp_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Encoder model: busy for enc_len cycles after each strobe it sees
  logic enc_en  = 1'b1;
  int   enc_len = 40;
  int   busy_cnt = 0;
  always @(posedge enc_clk) begin
    if ((tx_csw || tx_dw) && enc_en) begin
      busy_cnt <= enc_len;
      enc_busy <= 1'b1;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt <= 0;
      enc_busy <= 1'b0;
    end
  end

  // Transmit buffer: synchronous read, data valid the cycle after buf_rd_en
  logic [15:0] mem [32];
  always @(posedge enc_clk) if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];

  int cyc = 0;
  always @(posedge enc_clk) cyc <= cyc + 1;

  logic [16:0] exp_q[$];
  logic [4:0]  addr_q[$];

  int n_csw = 0, n_dw = 0, n_done = 0, n_err = 0, n_busy = 0;
  int csw_cyc = 0, err_cyc = 0, max_addr = 0, last_addr = 0;

  // Output monitor, sampled on the falling edge
  always @(negedge enc_clk) begin
    if (tx_csw || tx_dw) begin
      check_eq("strobe_excl", {31'd0, tx_csw && tx_dw}, 32'd0);
      check_eq("strobe_while_busy", {31'd0, enc_busy}, 32'd0);
      if (exp_q.size() == 0) check_eq("unexp_strobe", {30'd0, tx_csw, tx_dw}, 32'd0);
      else check_eq("tx_word", {15'd0, tx_csw, tx_word}, {15'd0, exp_q.pop_front()});
    end
    if (tx_csw) begin n_csw++; csw_cyc = cyc; end
    if (tx_dw) n_dw++;
    if (buf_rd_en) begin
      last_addr = int'(buf_rd_addr);
      if (last_addr > max_addr) max_addr = last_addr;
      if (addr_q.size() == 0) check_eq("unexp_rd", {31'd0, buf_rd_en}, 32'd0);
      else check_eq("rd_addr", {27'd0, buf_rd_addr}, {27'd0, addr_q.pop_front()});
    end
    if (resp_done) n_done++;
    if (resp_err) begin n_err++; err_cyc = cyc; end
    if (seq_busy) n_busy++;
  end

  function automatic logic [31:0] all_outs();
    return {buf_rd_en, buf_rd_addr, buf_sa, tx_csw, tx_dw, tx_word, seq_busy, resp_done, resp_err};
  endfunction

  int cmd_cyc = 0;

  task automatic push_exp(input int ndw);
    exp_q.push_back({1'b1, own_address, status_flags});
    for (int i = 0; i < ndw; i++) begin
      exp_q.push_back({1'b0, mem[i]});
      addr_q.push_back(5'(i));
    end
  endtask

  task automatic send_cmd(input logic [4:0] rt, input logic tr, input logic [4:0] sa,
                          input logic [4:0] cnt);
    @(negedge enc_clk);
    cmd_word  = {rt, tr, sa, cnt};
    cmd_valid = 1'b1;
    @(posedge enc_clk);
    #1;
    cmd_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input int budget, input int base);
    for (int i = 0; i < budget && (n_done + n_err) == base; i++) @(negedge enc_clk);
    @(negedge enc_clk);
    check_eq("resp_end", 32'(n_done + n_err), 32'(base + 1));
  endtask

  task automatic wait_enc_idle();
    for (int i = 0; i < 200 && enc_busy; i++) @(negedge enc_clk);
    check_eq("enc_idle", {31'd0, enc_busy}, 32'd0);
  endtask

  // Full normal transmit response with N data words and all timing checks
  task automatic normal_resp(input string tag, input logic [4:0] sa, input logic [4:0] cnt,
                             input int ndw);
    int b_dw, b_done, b_err;
    b_dw = n_dw; b_done = n_done; b_err = n_err;
    status_flags = 11'($urandom);
    push_exp(ndw);
    send_cmd(5'd5, 1'b1, sa, cnt);
    wait_end(3000, b_done + b_err);
    check_eq({tag, "_gap"}, 32'(csw_cyc - cmd_cyc), RESP_GAP);
    check_eq({tag, "_ndw"}, 32'(n_dw - b_dw), 32'(ndw));
    check_eq({tag, "_done"}, 32'(n_done - b_done), 32'd1);
    check_eq({tag, "_err"}, 32'(n_err - b_err), 32'd0);
    check_eq({tag, "_sb_empty"}, 32'(exp_q.size() + addr_q.size()), 32'd0);
    check_eq({tag, "_busy_end"}, {31'd0, seq_busy}, 32'd0);
  endtask

  initial begin
    int b_csw, b_dw, b_done, b_err, b_busy;
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    cmd_valid    = 1'b0;
    cmd_word     = '0;
    own_address  = 5'd5;
    status_flags = '0;
    abort        = 1'b0;
    rst_n        = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_eq("reset_outs", all_outs(), 32'd0);
    repeat (3) @(negedge enc_clk);
    check_eq("reset_outs_held", all_outs(), 32'd0);
    rst_n = 1'b1;

    // 1: three-word transmit
    normal_resp("t1", 5'd2, 5'd3, 3);
    check_eq("t1_max_addr", 32'(max_addr), 32'd2);
    check_eq("t1_sa", {27'd0, buf_sa}, 32'd2);

    // 2: dwcnt 0 means 32 words
    normal_resp("t2", 5'd7, 5'd0, 32);
    check_eq("t2_last_addr", 32'(last_addr), 32'd31);

    // 3: receive command and mode code are status-only
    b_dw = n_dw; b_done = n_done;
    status_flags = 11'($urandom);
    push_exp(0);
    send_cmd(5'd5, 1'b0, 5'd2, 5'd4);
    wait_end(500, b_done + n_err);
    push_exp(0);
    send_cmd(5'd5, 1'b1, 5'd31, 5'd4);
    wait_end(500, b_done + 1 + n_err);
    check_eq("t3_ndw", 32'(n_dw - b_dw), 32'd0);
    check_eq("t3_done", 32'(n_done - b_done), 32'd2);
    check_eq("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // 4: broadcast and foreign addresses are ignored
    b_csw = n_csw; b_busy = n_busy;
    send_cmd(5'd31, 1'b1, 5'd2, 5'd3);
    send_cmd(5'd6, 1'b1, 5'd2, 5'd3);
    repeat (30) @(negedge enc_clk);
    check_eq("t4_csw", 32'(n_csw - b_csw), 32'd0);
    check_eq("t4_busy", 32'(n_busy - b_busy), 32'd0);

    // 5: encoder never starts -> start timeout, then recovery
    enc_en = 1'b0;
    b_dw = n_dw; b_done = n_done; b_err = n_err;
    push_exp(0);
    send_cmd(5'd5, 1'b1, 5'd2, 5'd3);
    wait_end(500, b_done + b_err);
    check_eq("t5_err", 32'(n_err - b_err), 32'd1);
    check_eq("t5_err_lat", 32'(err_cyc - csw_cyc), START_TMO);
    check_eq("t5_ndw", 32'(n_dw - b_dw), 32'd0);
    check_eq("t5_done", 32'(n_done - b_done), 32'd0);
    check_eq("t5_idle", {31'd0, seq_busy}, 32'd0);
    enc_en = 1'b1;
    normal_resp("t5r", 5'd3, 5'd2, 2);

    // 6a: abort during the second data-word wait
    b_dw = n_dw; b_done = n_done; b_err = n_err;
    status_flags = 11'($urandom);
    push_exp(2);
    send_cmd(5'd5, 1'b1, 5'd4, 5'd3);
    for (int i = 0; i < 1000 && (n_dw - b_dw) < 2; i++) @(negedge enc_clk);
    repeat (5) @(negedge enc_clk);
    abort = 1'b1;
    @(posedge enc_clk);
    #1 abort = 1'b0;
    @(negedge enc_clk);
    check_eq("t6a_outs", all_outs(), 32'd0);
    repeat (100) @(negedge enc_clk);
    check_eq("t6a_ndw", 32'(n_dw - b_dw), 32'd2);
    check_eq("t6a_pulses", 32'(n_done - b_done + n_err - b_err), 32'd0);
    check_eq("t6a_sb_empty", 32'(exp_q.size() + addr_q.size()), 32'd0);
    wait_enc_idle();
    normal_resp("t6a_r", 5'd4, 5'd3, 3);

    // 6b: reset pulse during the response gap
    b_csw = n_csw; b_done = n_done; b_err = n_err;
    send_cmd(5'd5, 1'b1, 5'd9, 5'd3);
    repeat (4) @(negedge enc_clk);
    rst_n = 1'b0;
    #1 check_eq("t6b_async_outs", all_outs(), 32'd0);
    repeat (2) @(negedge enc_clk);
    rst_n = 1'b1;
    repeat (30) @(negedge enc_clk);
    check_eq("t6b_csw", 32'(n_csw - b_csw), 32'd0);
    check_eq("t6b_pulses", 32'(n_done - b_done + n_err - b_err), 32'd0);
    check_eq("t6b_outs", all_outs(), 32'd0);
    normal_resp("t6b_r", 5'd9, 5'd1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
